// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Measures each half-period of a slow monitored clock in cristal_i cycles, checks it
//   against NOMINAL +/- TOL, and raises a sticky lost_o flag after TIMEOUT cycles
//   without an edge.
//   Optional feature macro: CLK_MON_STATS_EN (min/max half-period tracking).
//   Without the macro, min_o/max_o are tied to zero and no stat registers exist.
module clk_period_monitor #(
   parameter int CNT_W   = 20,
   parameter int NOMINAL = 500000,
   parameter int TOL     = 5000,
   parameter int TIMEOUT = 1000000
) (
   input  logic             cristal_i,
   input  logic             RST_rst_n_i,
   input  logic             CLK_mon_i,
   input  logic             enable_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] half_period_o,
   output logic             level_o,
   output logic             valid_o,
   output logic             in_range_o,
   output logic             lost_o,
   output logic [CNT_W-1:0] min_o,
   output logic [CNT_W-1:0] max_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2,
      LOST = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LO_C   = CNT_W'(NOMINAL - TOL);
   localparam logic [CNT_W-1:0] HI_C   = CNT_W'(NOMINAL + TOL);
   localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);

   // synchronizer and edge-detector stages
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic dly_q,   dly_d;
   logic edge_s;

   // measurement state
   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             meas_s;

   // registered outputs
   logic [CNT_W-1:0] half_q, half_d;
   logic             level_q, level_d;
   logic             valid_q, valid_d;
   logic             in_range_q, in_range_d;
   logic             lost_q, lost_d;

   // Next values of the two-stage synchronizer and the delayed copy used for edge detection
   always_comb begin
      sync1_d = CLK_mon_i;
      sync2_d = sync1_q;
      dly_d   = sync2_q;
      edge_s  = sync2_q ^ dly_q;
   end

   // Measurement FSM: next state, half-period counter and sticky loss flag
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lost_d  = lost_q;
      meas_s  = 1'b0;
      if (!enable_i) begin
         // disabling always parks in IDLE; the loss flag is only touched by clear_i
         state_d = IDLE;
         count_d = ZERO_C;
         if (clear_i) begin
            lost_d = 1'b0;
         end else begin
            lost_d = lost_q;
         end
      end else begin
         case (state_q)
            IDLE: begin
               count_d = ZERO_C;
               state_d = ARM;
               if (clear_i) begin
                  lost_d = 1'b0;
               end else begin
                  lost_d = lost_q;
               end
            end
            ARM: begin
               // the half in progress when arming is partial, so only its closing edge matters
               if (clear_i) begin
                  lost_d  = 1'b0;
                  count_d = ZERO_C;
               end else if (edge_s) begin
                  state_d = MEAS;
                  count_d = ONE_C;
               end else begin
                  count_d = ZERO_C;
               end
            end
            MEAS: begin
               if (clear_i) begin
                  state_d = ARM;
                  lost_d  = 1'b0;
                  count_d = ZERO_C;
               end else if (edge_s) begin
                  // an edge arriving on the timeout cycle still counts as a measurement
                  meas_s  = 1'b1;
                  count_d = ONE_C;
               end else if (count_q == TO_C) begin
                  state_d = LOST;
                  lost_d  = 1'b1;
               end else begin
                  count_d = count_q + ONE_C;
               end
            end
            LOST: begin
               // edges are ignored until software re-arms; count stays saturated
               if (clear_i) begin
                  state_d = ARM;
                  lost_d  = 1'b0;
                  count_d = ZERO_C;
               end else begin
                  state_d = LOST;
               end
            end
            default: begin
               state_d = IDLE;
               count_d = ZERO_C;
            end
         endcase
      end
   end

   // Capture a completed half-period into the output registers
   always_comb begin
      valid_d    = meas_s;
      half_d     = half_q;
      level_d    = level_q;
      in_range_d = in_range_q;
      if (meas_s) begin
         half_d     = count_q;
         level_d    = dly_q;
         in_range_d = (count_q >= LO_C) && (count_q <= HI_C);
      end else begin
         half_d     = half_q;
         level_d    = level_q;
         in_range_d = in_range_q;
      end
   end

   // State, synchronizer and output registers
   always_ff @(posedge cristal_i or negedge RST_rst_n_i) begin
      if (!RST_rst_n_i) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         dly_q      <= 1'b0;
         state_q    <= IDLE;
         count_q    <= ZERO_C;
         half_q     <= ZERO_C;
         level_q    <= 1'b0;
         valid_q    <= 1'b0;
         in_range_q <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         dly_q      <= dly_d;
         state_q    <= state_d;
         count_q    <= count_d;
         half_q     <= half_d;
         level_q    <= level_d;
         valid_q    <= valid_d;
         in_range_q <= in_range_d;
         lost_q     <= lost_d;
      end
   end

   assign half_period_o = half_q;
   assign level_o       = level_q;
   assign valid_o       = valid_q;
   assign in_range_o    = in_range_q;
   assign lost_o        = lost_q;

`ifdef CLK_MON_STATS_EN
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic             seen_q, seen_d;

   // Min/max tracking; the first measurement after reset or clear seeds both
   always_comb begin
      min_d  = min_q;
      max_d  = max_q;
      seen_d = seen_q;
      if (clear_i) begin
         min_d  = ZERO_C;
         max_d  = ZERO_C;
         seen_d = 1'b0;
      end else if (meas_s) begin
         seen_d = 1'b1;
         if (!seen_q) begin
            min_d = count_q;
            max_d = count_q;
         end else begin
            if (count_q < min_q) begin
               min_d = count_q;
            end else begin
               min_d = min_q;
            end
            if (count_q > max_q) begin
               max_d = count_q;
            end else begin
               max_d = max_q;
            end
         end
      end else begin
         min_d  = min_q;
         max_d  = max_q;
         seen_d = seen_q;
      end
   end

   // Statistics registers
   always_ff @(posedge cristal_i or negedge RST_rst_n_i) begin
      if (!RST_rst_n_i) begin
         min_q  <= ZERO_C;
         max_q  <= ZERO_C;
         seen_q <= 1'b0;
      end else begin
         min_q  <= min_d;
         max_q  <= max_d;
         seen_q <= seen_d;
      end
   end

   assign min_o = min_q;
   assign max_o = max_q;
`else
   assign min_o = ZERO_C;
   assign max_o = ZERO_C;
`endif

endmodule
